// File: rtl/td4_board_ctrl_if.sv
// Board-side signal bundle for td4_board_ctrl: mode/step/display inputs and TD4 clock,
// segment and digit-enable outputs. master = controller, slave = board/driver side.
interface td4_board_ctrl_if #(
   parameter int unsigned NumDigits = 4
);
   logic                     mode;
   logic                     step;
   logic [4*NumDigits-1:0]   disp;
   logic [NumDigits-1:0]     dp;
   logic                     td4_tick;
   logic                     td4_clk;
   logic [8:1]               seg;
   logic [NumDigits-1:0]     dig_en;

   modport master (
      input  mode, step, disp, dp,
      output td4_tick, td4_clk, seg, dig_en
   );

   modport slave (
      output mode, step, disp, dp,
      input  td4_tick, td4_clk, seg, dig_en
   );
endinterface

// File: rtl/td4_board_ctrl.sv
// TD4 board controller: free-run / debounced single-step clock plus multiplexed 7-segment scan.
// Optional feature macro: TD4_LEADING_ZERO_BLANK_EN (blank digits above the top non-zero nibble).
module td4_board_ctrl #(
   parameter int unsigned ClkHz     = 50_000_000,
   parameter int unsigned RunHz     = 1,
   parameter int unsigned ScanHz    = 1000,
   parameter int unsigned NumDigits = 4,
   parameter int unsigned BlankCyc  = 1,
   parameter int unsigned DebCyc    = 500_000
) (
   input logic              clk,
   input logic              rst_n,
   td4_board_ctrl_if.master bus
);
   localparam int unsigned RunDiv  = ClkHz / RunHz;
   localparam int unsigned HalfDiv = RunDiv / 2;
   localparam int unsigned Slot    = ClkHz / (ScanHz * NumDigits);
   localparam int unsigned ShowCyc = Slot - BlankCyc;
   localparam int unsigned DivW    = $clog2(RunDiv);
   localparam int unsigned SlotW   = $clog2(Slot);
   localparam int unsigned DebW    = $clog2(DebCyc + 1);
   localparam int unsigned IdxW    = (NumDigits > 1) ? $clog2(NumDigits) : 1;
   localparam int unsigned PendW   = 4;

   if (RunDiv < 2) begin : gen_bad_run_div
      $error("td4_board_ctrl: ClkHz/RunHz must be >= 2");
   end
   if (Slot < 2 || BlankCyc >= Slot) begin : gen_bad_slot
      $error("td4_board_ctrl: scan slot must be >= 2 and longer than BlankCyc");
   end
   if (NumDigits < 1 || NumDigits > 8) begin : gen_bad_digits
      $error("td4_board_ctrl: NumDigits must be 1..8");
   end

   // ---------------------------------------------------------------- input synchronisers
   logic mode_s1_q, mode_q;
   logic step_s1_q, step_s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_s1_q <= 1'b0;
         mode_q    <= 1'b0;
         step_s1_q <= 1'b0;
         step_s2_q <= 1'b0;
      end else begin
         mode_s1_q <= bus.mode;
         mode_q    <= mode_s1_q;
         step_s1_q <= bus.step;
         step_s2_q <= step_s1_q;
      end
   end

   // ---------------------------------------------------------------- button debounce
   logic            deb_q;
   logic [DebW-1:0] deb_cnt_q;
   logic            deb_flip;
   logic            press;

   assign deb_flip = (step_s2_q != deb_q) && (deb_cnt_q == DebW'(DebCyc - 1));
   assign press    = deb_flip && !deb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q     <= 1'b0;
         deb_cnt_q <= '0;
      end else if (step_s2_q == deb_q) begin
         deb_cnt_q <= '0;
      end else if (deb_flip) begin
         deb_q     <= step_s2_q;
         deb_cnt_q <= '0;
      end else begin
         deb_cnt_q <= deb_cnt_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------- TD4 clock generation
   logic             mode_chg;
   logic [DivW-1:0]  div_q;
   logic [DivW-1:0]  hi_cnt_q;
   logic [PendW-1:0] pend_q;
   logic [PendW:0]   pend_avail;
   logic             tick_q;
   logic             td4_clk_q;
   logic             run_tick;
   logic             step_go;

   // mode_s1_q differing from mode_q means the synced mode flips on this edge
   assign mode_chg = mode_s1_q != mode_q;

   always_comb begin
      run_tick   = !mode_q && !mode_chg && (div_q == DivW'(RunDiv - 1));
      pend_avail = {1'b0, pend_q} + (PendW + 1)'(press);
      step_go    = mode_q && !mode_chg && !td4_clk_q && (pend_avail != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q     <= '0;
         hi_cnt_q  <= '0;
         pend_q    <= '0;
         tick_q    <= 1'b0;
         td4_clk_q <= 1'b0;
      end else begin
         tick_q <= run_tick || step_go;

         if (mode_chg || mode_q || run_tick) begin
            div_q <= '0;
         end else begin
            div_q <= div_q + 1'b1;
         end

         if (run_tick || step_go) begin
            td4_clk_q <= 1'b1;
            hi_cnt_q  <= DivW'(HalfDiv - 1);
         end else if (td4_clk_q) begin
            if (hi_cnt_q == '0) begin
               td4_clk_q <= 1'b0;
            end else begin
               hi_cnt_q <= hi_cnt_q - 1'b1;
            end
         end

         // presses that arrive while the clock is high wait here for their own tick
         if (!mode_q || mode_chg) begin
            pend_q <= '0;
         end else if (step_go) begin
            pend_q <= PendW'(pend_avail - 1'b1);
         end else if (pend_avail[PendW]) begin
            pend_q <= '1;
         end else begin
            pend_q <= pend_avail[PendW-1:0];
         end
      end
   end

   assign bus.td4_tick = tick_q;
   assign bus.td4_clk  = td4_clk_q;

   // ---------------------------------------------------------------- display scan
   typedef enum logic [1:0] {StIdle, StShow, StBlank} scan_state_e;

   scan_state_e          state_q;
   logic [IdxW-1:0]      idx_q;
   logic [IdxW-1:0]      show_idx;
   logic [SlotW-1:0]     slot_q;
   logic [8:1]           seg_q;
   logic [8:1]           seg_show;
   logic [NumDigits-1:0] dig_en_q;
   logic [NumDigits-1:0] dig_show;
   logic                 show_done;
   logic                 blank_done;
   logic                 enter_show;
   logic [3:0]           nib;
   logic                 dp_bit;
   logic                 lz_blank;
`ifdef TD4_LEADING_ZERO_BLANK_EN
   logic [IdxW-1:0]      msnz;
`endif

   function automatic logic [6:0] font(input logic [3:0] v);
      logic [6:0] f;
      case (v)
         4'h0: f = 7'h3F;
         4'h1: f = 7'h06;
         4'h2: f = 7'h5B;
         4'h3: f = 7'h4F;
         4'h4: f = 7'h66;
         4'h5: f = 7'h6D;
         4'h6: f = 7'h7D;
         4'h7: f = 7'h07;
         4'h8: f = 7'h7F;
         4'h9: f = 7'h6F;
         4'hA: f = 7'h77;
         4'hB: f = 7'h7C;
         4'hC: f = 7'h39;
         4'hD: f = 7'h5E;
         4'hE: f = 7'h79;
         default: f = 7'h71;
      endcase
      return f;
   endfunction

   always_comb begin
      show_done  = slot_q == SlotW'(ShowCyc - 1);
      blank_done = slot_q == SlotW'(BlankCyc - 1);

      enter_show = 1'b0;
      case (state_q)
         StIdle:  enter_show = 1'b1;
         StShow:  enter_show = show_done && (BlankCyc == 0);
         StBlank: enter_show = blank_done;
         default: enter_show = 1'b0;
      endcase

      if (state_q == StIdle) begin
         show_idx = '0;
      end else if (idx_q == IdxW'(NumDigits - 1)) begin
         show_idx = '0;
      end else begin
         show_idx = idx_q + 1'b1;
      end

      nib      = 4'h0;
      dp_bit   = 1'b0;
      dig_show = '1;
      for (int unsigned k = 0; k < NumDigits; k++) begin
         if (IdxW'(k) == show_idx) begin
            nib         = bus.disp[4*k +: 4];
            dp_bit      = bus.dp[k];
            dig_show[k] = 1'b0;
         end
      end

`ifdef TD4_LEADING_ZERO_BLANK_EN
      msnz = '0;
      for (int unsigned k = 0; k < NumDigits; k++) begin
         if (bus.disp[4*k +: 4] != 4'h0) begin
            msnz = IdxW'(k);
         end
      end
      lz_blank = show_idx > msnz;
`else
      lz_blank = 1'b0;
`endif

      seg_show = {~dp_bit, lz_blank ? 7'h7F : ~font(nib)};
   end

   // seg_q/dig_en_q are captured once at SHOW entry, so a slot never tears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         slot_q   <= '0;
         seg_q    <= '1;
         dig_en_q <= '1;
      end else if (enter_show) begin
         state_q  <= StShow;
         idx_q    <= show_idx;
         slot_q   <= '0;
         seg_q    <= seg_show;
         dig_en_q <= dig_show;
      end else begin
         case (state_q)
            StShow: begin
               if (show_done) begin
                  state_q  <= StBlank;
                  slot_q   <= '0;
                  seg_q    <= '1;
                  dig_en_q <= '1;
               end else begin
                  slot_q <= slot_q + 1'b1;
               end
            end
            StBlank: slot_q <= slot_q + 1'b1;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.seg    = seg_q;
   assign bus.dig_en = dig_en_q;
endmodule
